// File: rtl/addr_gen_pkg.sv
// Shared constants and types for the March C- SRAM address generator.
package addr_gen_pkg;

  localparam int ADDR_W   = 7;
  localparam int DEPTH    = 2 ** ADDR_W;
  localparam int MARCH_N  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Bit i is the sweep direction of element i: UP, UP, UP, DOWN, DOWN, UP.
  localparam logic [MARCH_N-1:0] MARCH_C_DIR = 6'b01_1000;

  // Elements beyond the table sweep upward.
  function automatic dir_e elem_dir(input int idx);
    if (idx >= 0 && idx < MARCH_N) return dir_e'(MARCH_C_DIR[idx]);
    return DIR_UP;
  endfunction

endpackage

// File: rtl/addr_updown_cnt.sv
// Loadable up/down address counter with a terminal-count flag for the
// current sweep direction.
module addr_updown_cnt
  import addr_gen_pkg::*;
#(
  parameter int ADDR_W = addr_gen_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              en,
  input  dir_e              dir,
  output logic [ADDR_W-1:0] cnt,
  output logic              tc
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= (dir == DIR_UP) ? cnt + 1'b1 : cnt - 1'b1;
    end
  end

  assign tc = (dir == DIR_UP) ? (cnt == '1) : (cnt == '0);

endmodule

// File: rtl/addr_gen.sv
// March C- address sequencer: sweeps every element of the test across the
// whole SRAM, holding each address HOLD_CYC cycles, then flags completion.
module addr_gen
  import addr_gen_pkg::*;
#(
  parameter int ADDR_W   = addr_gen_pkg::ADDR_W,
  parameter int NUM_ELEM = 6,
  parameter int HOLD_CYC = 1
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              MBISTEN,
  output logic [ADDR_W-1:0] ADDR,
  output logic              ADDR_done
);

  localparam int ELEM_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;

  state_e              state;
  logic [ELEM_W-1:0]   elem;
  logic [2:0]          hold_cnt;

  logic                hold_last;
  logic                last_elem;
  logic                tc;
  dir_e                cur_dir;
  dir_e                next_dir;
  logic                cnt_load;
  logic                cnt_en;
  logic [ADDR_W-1:0]   cnt_val;

  assign hold_last = (hold_cnt == 3'(HOLD_CYC - 1));
  assign last_elem = (elem == ELEM_W'(NUM_ELEM - 1));
  assign cur_dir   = elem_dir(int'(elem));
  assign next_dir  = elem_dir(int'(elem) + 1);

  // Outside an active sweep the counter is parked at 0; at an element end it
  // loads the next start address directly so no idle cycle is inserted.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cnt_load = 1'b1;
    cnt_val  = '0;
    cnt_en   = 1'b0;
    if (state == RUN && MBISTEN) begin
      cnt_load = 1'b0;
      if (hold_last) begin
        if (tc) begin
          cnt_load = 1'b1;
          if (!last_elem && next_dir == DIR_DOWN) cnt_val = '1;
        end else begin
          cnt_en = 1'b1;
        end
      end
    end
  end

  addr_updown_cnt #(.ADDR_W(ADDR_W)) u_cnt (
    .clk      (CLK),
    .rst_n    (nRESET),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .dir      (cur_dir),
    .cnt      (ADDR),
    .tc       (tc)
  );

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state     <= IDLE;
      elem      <= '0;
      hold_cnt  <= '0;
      ADDR_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          elem      <= '0;
          hold_cnt  <= '0;
          ADDR_done <= 1'b0;
          if (MBISTEN) state <= RUN;
        end
        RUN: begin
          if (!MBISTEN) begin
            state    <= IDLE;
            elem     <= '0;
            hold_cnt <= '0;
          end else if (hold_last) begin
            hold_cnt <= '0;
            if (tc) begin
              if (last_elem) begin
                state     <= DONE;
                elem      <= '0;
                ADDR_done <= 1'b1;
              end else begin
                elem <= elem + 1'b1;
              end
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        DONE: begin
          if (!MBISTEN) begin
            state     <= IDLE;
            ADDR_done <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          elem      <= '0;
          hold_cnt  <= '0;
          ADDR_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addr_gen.sv
// Randomized bench for addr_gen at HOLD_CYC=1 and HOLD_CYC=2 against an
// arithmetic model of the March C- address sequence.
module tb_addr_gen;

  localparam int NE    = 6;
  localparam int DEPTH = 128;

  logic       CLK;
  logic       nRESET;
  logic       MBISTEN;
  logic [6:0] addr_h1, addr_h2;
  logic       done_h1, done_h2;

  addr_gen #(.ADDR_W(7), .NUM_ELEM(NE), .HOLD_CYC(1)) dut_h1 (
    .CLK(CLK), .nRESET(nRESET), .MBISTEN(MBISTEN), .ADDR(addr_h1), .ADDR_done(done_h1)
  );

  addr_gen #(.ADDR_W(7), .NUM_ELEM(NE), .HOLD_CYC(2)) dut_h2 (
    .CLK(CLK), .nRESET(nRESET), .MBISTEN(MBISTEN), .ADDR(addr_h2), .ADDR_done(done_h2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: phase 0 idle, 1 run, 2 done; t = edges since RUN entry.
  int hold_of [2] = '{1, 2};
  int phase   [2] = '{0, 0};
  int t       [2] = '{0, 0};
  int entry   [2] = '{0, 0};
  bit prev_done [2] = '{1'b0, 1'b0};

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // March C-: elements 3 and 4 sweep downward, all others upward.
  function automatic int exp_addr(input int tt, input int h);
    int per = DEPTH * h;
    int e   = tt / per;
    int pos = (tt % per) / h;
    return (e == 3 || e == 4) ? (DEPTH - 1 - pos) : pos;
  endfunction

  task automatic step();
    int obs_a, obs_d;
    @(posedge CLK);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!nRESET) begin
        phase[k] = 0;
        t[k]     = 0;
      end else begin
        case (phase[k])
          0: if (MBISTEN) begin phase[k] = 1; t[k] = 0; entry[k] = cyc; end
          1: if (!MBISTEN) phase[k] = 0;
             else begin
               t[k]++;
               if (t[k] == NE * DEPTH * hold_of[k]) phase[k] = 2;
             end
          default: if (!MBISTEN) phase[k] = 0;
        endcase
      end
    end
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      obs_a = (k == 0) ? int'(addr_h1) : int'(addr_h2);
      obs_d = (k == 0) ? int'(done_h1) : int'(done_h2);
      check($sformatf("addr_h%0d", hold_of[k]), obs_a,
            (phase[k] == 1) ? exp_addr(t[k], hold_of[k]) : 0);
      check($sformatf("done_h%0d", hold_of[k]), obs_d, (phase[k] == 2) ? 1 : 0);
      if (obs_d == 1 && !prev_done[k])
        check($sformatf("done_rise_h%0d", hold_of[k]), cyc - entry[k],
              NE * DEPTH * hold_of[k]);
      prev_done[k] = (obs_d == 1);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    nRESET  = 1'b0;
    MBISTEN = 1'b1;
    repeat (3) step();

    // Release with enable already high: run starts on the first edge.
    nRESET = 1'b1;
    repeat (1600) step();

    // Leave DONE, then start a new run.
    MBISTEN = 1'b0;
    repeat ($urandom_range(1, 4)) step();
    MBISTEN = 1'b1;
    repeat (1600) step();

    // Abort at elem 1, ADDR 50 on the HOLD_CYC=1 instance.
    MBISTEN = 1'b0;
    step();
    MBISTEN = 1'b1;
    repeat (1 + DEPTH + 50) step();
    check("abort_point", int'(addr_h1), 50);
    MBISTEN = 1'b0;
    step();
    check("abort_addr", int'(addr_h1), 0);
    MBISTEN = 1'b1;
    repeat (1600) step();

    for (int i = 0; i < 12; i++) begin
      MBISTEN = 1'b1;
      repeat ($urandom_range(1, 1700)) step();
      if ($urandom_range(0, 3) == 0) begin
        nRESET  = 1'b0;
        MBISTEN = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 3)) step();
        nRESET  = 1'b1;
      end else begin
        MBISTEN = 1'b0;
        repeat ($urandom_range(1, 3)) step();
      end
    end

    MBISTEN = 1'b1;
    repeat (1600) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
